uart_bus_master: RTL and testbench

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: decodes host packets arriving on rx_pin into single 32-bit
// bus reads/writes and returns the status/read-data bytes on tx_pin.
`timescale 1ns/1ps
module uart_bus_master #(
    parameter logic [15:0] CLK_DIV = 16'h1B8,
    parameter logic [31:0] TIMEOUT = 32'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_gnt_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {S_SYNC, S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    localparam logic [15:0] BIT_M1  = CLK_DIV - 16'd1;
    localparam logic [15:0] HALF_M1 = (CLK_DIV >> 1) - 16'd1;

    logic        rx_s1_q, rx_s2_q;
    logic        rx_armed_q, rx_armed_d;
    logic        rx_active_q, rx_active_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_vld_q, rx_vld_d;
    logic        rx_ferr_q, rx_ferr_d;

    logic        tx_active_q, tx_active_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [9:0]  tx_shift_q, tx_shift_d;
    logic        tx_ready, tx_load;
    logic [7:0]  tx_byte;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [39:0] resp_buf_q, resp_buf_d;
    logic [2:0]  resp_len_q, resp_len_d;
    logic        mem_req_q, mem_req_d;

    // RX sampler: a new frame only starts once the line has been seen high (armed),
    // so a line held low after reset or after a framing error cannot fake a start.
    always_comb begin
        rx_armed_d  = rx_armed_q;
        rx_active_d = rx_active_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_vld_d    = 1'b0;
        rx_ferr_d   = 1'b0;
        if (!rx_active_q) begin
            if (rx_s2_q) begin
                rx_armed_d = 1'b1;
            end else if (rx_armed_q) begin
                rx_active_d = 1'b1;
                rx_armed_d  = 1'b0;
                rx_cnt_d    = HALF_M1;
                rx_bit_d    = 4'd0;
            end
        end else if (rx_cnt_q != 16'd0) begin
            rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
            rx_cnt_d = BIT_M1;
            if (rx_bit_q == 4'd0) begin
                if (rx_s2_q) rx_active_d = 1'b0;
                else         rx_bit_d    = 4'd1;
            end else if (rx_bit_q == 4'd9) begin
                rx_active_d = 1'b0;
                rx_vld_d    = rx_s2_q;
                rx_ferr_d   = !rx_s2_q;
            end else begin
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
            end
        end
    end

    // A new byte may be loaded in the last cycle of the stop bit, giving zero idle gap.
    assign tx_ready = !tx_active_q || (tx_bit_q == 4'd9 && tx_cnt_q == 16'd0);

    always_comb begin
        tx_active_d = tx_active_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        if (tx_load) begin
            tx_active_d = 1'b1;
            tx_shift_d  = {1'b1, tx_byte, 1'b0};
            tx_cnt_d    = BIT_M1;
            tx_bit_d    = 4'd0;
        end else if (tx_active_q) begin
            if (tx_cnt_q != 16'd0) begin
                tx_cnt_d = tx_cnt_q - 16'd1;
            end else if (tx_bit_q == 4'd9) begin
                tx_active_d = 1'b0;
            end else begin
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_bit_d   = tx_bit_q + 4'd1;
                tx_cnt_d   = BIT_M1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        to_cnt_d   = to_cnt_q;
        resp_buf_d = resp_buf_q;
        resp_len_d = resp_len_q;
        mem_req_d  = mem_req_q;
        tx_load    = 1'b0;
        tx_byte    = resp_buf_q[7:0];
        case (state_q)
            S_SYNC: begin
                if (rx_vld_q && rx_shift_q == 8'hA5) begin
                    state_d  = S_CMD;
                    to_cnt_d = 32'd0;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                to_cnt_d = to_cnt_q + 32'd1;
                if (rx_ferr_q) begin
                    state_d = S_SYNC;
                end else if (rx_vld_q) begin
                    to_cnt_d = 32'd0;
                    if (state_q == S_CMD) begin
                        if (rx_shift_q == 8'h01 || rx_shift_q == 8'h02) begin
                            is_wr_d    = (rx_shift_q == 8'h01);
                            byte_cnt_d = 2'd0;
                            state_d    = S_ADDR;
                        end else begin
                            resp_buf_d = {32'd0, 8'hEE};
                            resp_len_d = 3'd1;
                            state_d    = S_RESP;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (state_q == S_ADDR) addr_d  = {rx_shift_q, addr_q[31:8]};
                        else                   wdata_d = {rx_shift_q, wdata_q[31:8]};
                        if (byte_cnt_q == 2'd3) begin
                            if (state_q == S_ADDR && is_wr_q) begin
                                state_d = S_DATA;
                            end else begin
                                state_d   = S_BUS;
                                mem_req_d = 1'b1;
                            end
                        end
                    end
                end else if (to_cnt_d == TIMEOUT) begin
                    state_d = S_SYNC;
                end
            end
            S_BUS: begin
                if (mem_req_q && mem_gnt_i) begin
                    mem_req_d  = 1'b0;
                    resp_buf_d = is_wr_q ? {32'd0, 8'h5A} : {mem_rdata_i, 8'h5A};
                    resp_len_d = is_wr_q ? 3'd1 : 3'd5;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_len_q != 3'd0) begin
                    if (tx_ready) begin
                        tx_load    = 1'b1;
                        resp_buf_d = {8'd0, resp_buf_q[39:8]};
                        resp_len_d = resp_len_q - 3'd1;
                    end
                end else if (!tx_active_q) begin
                    state_d = S_SYNC;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b0;
            rx_s2_q     <= 1'b0;
            rx_armed_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_cnt_q    <= 16'd0;
            rx_bit_q    <= 4'd0;
            rx_shift_q  <= 8'd0;
            rx_vld_q    <= 1'b0;
            rx_ferr_q   <= 1'b0;
            tx_active_q <= 1'b0;
            tx_cnt_q    <= 16'd0;
            tx_bit_q    <= 4'd0;
            tx_shift_q  <= 10'd0;
            state_q     <= S_SYNC;
            byte_cnt_q  <= 2'd0;
            is_wr_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            to_cnt_q    <= 32'd0;
            resp_buf_q  <= 40'd0;
            resp_len_q  <= 3'd0;
            mem_req_q   <= 1'b0;
        end else begin
            rx_s1_q     <= rx_pin;
            rx_s2_q     <= rx_s1_q;
            rx_armed_q  <= rx_armed_d;
            rx_active_q <= rx_active_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_vld_q    <= rx_vld_d;
            rx_ferr_q   <= rx_ferr_d;
            tx_active_q <= tx_active_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            to_cnt_q    <= to_cnt_d;
            resp_buf_q  <= resp_buf_d;
            resp_len_q  <= resp_len_d;
            mem_req_q   <= mem_req_d;
        end
    end

    assign tx_pin      = tx_active_q ? tx_shift_q[0] : 1'b1;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = is_wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_SYNC);

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: host packets in, expected bus transfers
// and response bytes queued, independent monitors pop and compare.
`timescale 1ns/1ps
module tb_uart_bus_master;

    localparam int BITC = 8;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } tx_exp_t;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_pin = 1'b1;
    logic        tx_pin;
    logic        mem_req_o, mem_we_o, busy_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'hBAD0BAD0;
    logic        mem_gnt_i = 1'b0;

    tx_exp_t     tx_q[$];
    mem_exp_t    mem_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          tx_starts = 0;
    int          stray_req = 0;
    logic [31:0] rd_val = 32'd0;

    uart_bus_master #(.CLK_DIV(16'd8), .TIMEOUT(32'd200)) dut (
        .clk(clk), .rst(rst), .rx_pin(rx_pin), .tx_pin(tx_pin),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_gnt_i(mem_gnt_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check32(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Bus responder and bus-side scoreboard check.
    initial begin
        int       wait_n;
        int       stray_done;
        bit       granted;
        mem_exp_t e;
        wait_n = 0; stray_done = 0; granted = 0;
        forever begin
            @(negedge clk);
            if (mem_gnt_i) begin
                if (granted) check32("req_drop_after_gnt", {31'd0, mem_req_o}, 32'd0);
                mem_gnt_i   = 1'b0;
                mem_rdata_i = 32'hBAD0BAD0;
                granted     = 0;
                wait_n      = 0;
            end else if (stray_req != stray_done) begin
                stray_done++;
                mem_gnt_i = 1'b1;
            end else if (mem_req_o) begin
                wait_n++;
                if (wait_n == 3) begin
                    if (mem_q.size() == 0) begin
                        check32("mem_unexpected_req", 32'd1, 32'd0);
                    end else begin
                        e = mem_q.pop_front();
                        check32("mem_we", {31'd0, mem_we_o}, {31'd0, e.we});
                        check32("mem_addr", mem_addr_o, e.addr);
                        if (e.we) check32("mem_wdata", mem_wdata_o, e.wdata);
                    end
                    mem_gnt_i   = 1'b1;
                    mem_rdata_i = rd_val;
                    granted     = 1;
                end
            end
        end
    end

    // TX monitor: decodes frames; a frame interrupted by reset is abandoned.
    initial begin
        int         start, last_start;
        bit         aborted;
        logic [9:0] bits;
        tx_exp_t    e;
        last_start = -1000;
        forever begin
            @(negedge clk);
            if (tx_pin === 1'b0 && !rst) begin
                start = cyc;
                tx_starts++;
                aborted = 0;
                for (int i = 0; i < 10; i++) begin
                    repeat ((i == 0) ? 4 : BITC) begin
                        @(negedge clk);
                        if (rst) aborted = 1;
                    end
                    bits[i] = tx_pin;
                end
                if (!aborted) begin
                    if (tx_q.size() == 0) begin
                        check32("tx_unexpected_byte", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        e = tx_q.pop_front();
                        check32("tx_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
                        check32("tx_start_stop", {30'd0, bits[9], bits[0]}, 32'd2);
                        if (e.b2b) check32("tx_b2b_spacing", 32'(start - last_start), 32'd80);
                    end
                end
                last_start = start;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_pin = fr[i];
            repeat (BITC) @(negedge clk);
        end
        rx_pin = 1'b1;
    endtask

    task automatic send_bytes(input bytes_t b);
        foreach (b[i]) send_byte(b[i], 1'b1);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (tx_q.size() == 0 && mem_q.size() == 0 && busy_o == 1'b0 && !mem_gnt_i)
                done = 1;
        end
        check32(name, {31'd0, done}, 32'd1);
    endtask

    task automatic push_tx(input logic [7:0] d, input bit b2b);
        tx_exp_t e;
        e.data = d; e.b2b = b2b;
        tx_q.push_back(e);
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] w);
        mem_exp_t e;
        e.we = we; e.addr = a; e.wdata = w;
        mem_q.push_back(e);
    endtask

    initial begin
        int base;
        bit seen;
        repeat (3) @(negedge clk);
        check32("rst_tx_pin", {31'd0, tx_pin}, 32'd1);
        check32("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check32("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        check32("rst_mem_addr", mem_addr_o, 32'd0);
        check32("rst_mem_wdata", mem_wdata_o, 32'd0);
        check32("rst_busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write packet
        push_mem(1'b1, 32'h2000_0010, 32'hDEAD_BEEF);
        push_tx(8'h5A, 0);
        send_bytes('{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        wait_idle("write_done");

        // Read packet with back-to-back response
        rd_val = 32'h1234_5678;
        push_mem(1'b0, 32'h1000_0004, 32'd0);
        push_tx(8'h5A, 0); push_tx(8'h78, 1); push_tx(8'h56, 1); push_tx(8'h34, 1); push_tx(8'h12, 1);
        send_bytes('{8'hA5, 8'h02, 8'h04, 8'h00, 8'h00, 8'h10});
        wait_idle("read_done");

        // Stray grant while idle, then sync hunt and bad command
        stray_req++;
        repeat (5) @(negedge clk);
        push_tx(8'hEE, 0);
        send_bytes('{8'h00, 8'hFF, 8'hA5, 8'h07});
        wait_idle("badcmd_done");
        check32("badcmd_busy", {31'd0, busy_o}, 32'd0);

        // Timeout on partial packet, then a full write
        send_bytes('{8'hA5, 8'h01, 8'h10});
        repeat (250) @(negedge clk);
        check32("timeout_busy", {31'd0, busy_o}, 32'd0);
        push_mem(1'b1, 32'h0000_0040, 32'h0102_0304);
        push_tx(8'h5A, 0);
        send_bytes('{8'hA5, 8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01});
        wait_idle("after_timeout_done");

        // Framing error after sync
        send_byte(8'hA5, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (120) @(negedge clk);
        check32("ferr_busy", {31'd0, busy_o}, 32'd0);
        check32("ferr_tx_idle", {31'd0, tx_pin}, 32'd1);
        check32("ferr_no_req", {31'd0, mem_req_o}, 32'd0);

        // Reset during the second response byte, then a fresh read
        rd_val = 32'h1234_5678;
        push_mem(1'b0, 32'h1000_0004, 32'd0);
        push_tx(8'h5A, 0);
        base = tx_starts;
        send_bytes('{8'hA5, 8'h02, 8'h04, 8'h00, 8'h00, 8'h10});
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (tx_starts >= base + 2) seen = 1;
        end
        check32("second_resp_byte_started", {31'd0, seen}, 32'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check32("midrst_tx_pin", {31'd0, tx_pin}, 32'd1);
        check32("midrst_busy", {31'd0, busy_o}, 32'd0);
        check32("midrst_req", {31'd0, mem_req_o}, 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        rd_val = 32'hCAFE_F00D;
        push_mem(1'b0, 32'h3000_0008, 32'd0);
        push_tx(8'h5A, 0); push_tx(8'h0D, 1); push_tx(8'hF0, 1); push_tx(8'hFE, 1); push_tx(8'hCA, 1);
        send_bytes('{8'hA5, 8'h02, 8'h08, 8'h00, 8'h00, 8'h30});
        wait_idle("post_reset_read_done");

        check32("tx_queue_empty", tx_q.size(), 32'd0);
        check32("mem_queue_empty", mem_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
